// File: rtl/imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_arbiter_if
// Bundles every signal between the instruction-memory arbiter, its two
// requesters and the single-port instruction memory.
//   fetch  : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
//   loader : ld_req, ld_we, ld_addr, ld_wdata, ld_lock -> ld_gnt, ld_rvalid,
//            ld_rdata
//   status : lock_active, lock_timeout
//   memory : mem_addr, mem_we, mem_wdata -> mem_rdata (registered read)
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory)
// ---------------------------------------------------------------------------
interface imem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_lock;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              lock_active;
    logic              lock_timeout;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rvalid, f_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output ld_gnt, ld_rvalid, ld_rdata,
        output lock_active, lock_timeout,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rvalid, f_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  lock_active, lock_timeout,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Shares a single-port, synchronous-read instruction memory between the core
// fetch stage (F, read-only) and a loader/debug port (L, read or write).
// One access is granted per cycle; read data returns one cycle after the
// grant and is steered to the winner with an rvalid strobe.
// A level-sensitive loader lock gives L exclusive access; a watchdog ends the
// exclusivity after LOCK_MAX consecutive locked cycles and raises a sticky
// lock_timeout flag.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - imem_arbiter_if.slave (fetch, loader, status and memory signals)
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOCK    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    // Round-robin memory: which requester won the most recent grant.
    localparam logic RR_F = 1'b0;
    localparam logic RR_L = 1'b1;

    state_t            state_reg, state_next;
    logic              rr_last_reg, rr_last_next;
    logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;
    logic              lock_active_reg;
    logic              lock_timeout_reg, lock_timeout_next;
    logic              f_rvalid_reg, ld_rvalid_reg;
    logic              f_gnt_c, ld_gnt_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] rdata_w;

    // -----------------------------------------------------------------------
    // Arbitration and next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        f_gnt_c           = 1'b0;
        ld_gnt_c          = 1'b0;
        state_next        = state_reg;
        lock_cnt_next     = '0;
        lock_timeout_next = lock_timeout_reg;

        // Grants are held low for the whole time reset is asserted.
        if (rst_n) begin
            if (state_reg == ST_LOCK) begin
                ld_gnt_c = bus.ld_req;
            end else if (bus.f_req && bus.ld_req) begin
                // Contention: the side that did not win last time goes first.
                if (rr_last_reg == RR_L) f_gnt_c  = 1'b1;
                else                     ld_gnt_c = 1'b1;
            end else begin
                f_gnt_c  = bus.f_req;
                ld_gnt_c = bus.ld_req;
            end
        end

        case (state_reg)
            ST_RUN: begin
                if (bus.ld_lock) state_next = ST_LOCK;
            end
            ST_LOCK: begin
                if (!bus.ld_lock) begin
                    state_next = ST_RUN;
                end else if (lock_cnt_reg == LOCK_LAST) begin
                    // This was the LOCK_MAX-th locked cycle: hand fetch back.
                    state_next        = ST_TIMEOUT;
                    lock_timeout_next = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (!bus.ld_lock) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase

        if (f_gnt_c)       rr_last_next = RR_F;
        else if (ld_gnt_c) rr_last_next = RR_L;
        else               rr_last_next = rr_last_reg;
    end

    // -----------------------------------------------------------------------
    // State and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_RUN;
            rr_last_reg      <= RR_L;
            lock_cnt_reg     <= '0;
            lock_active_reg  <= 1'b0;
            lock_timeout_reg <= 1'b0;
            f_rvalid_reg     <= 1'b0;
            ld_rvalid_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rr_last_reg      <= rr_last_next;
            lock_cnt_reg     <= lock_cnt_next;
            lock_active_reg  <= (state_next == ST_LOCK);
            lock_timeout_reg <= lock_timeout_next;
            // Owner tag for the read data the memory returns next cycle.
            f_rvalid_reg     <= f_gnt_c;
            ld_rvalid_reg    <= ld_gnt_c && !bus.ld_we;
        end
    end

    // -----------------------------------------------------------------------
    // Memory port mux and outputs
    // -----------------------------------------------------------------------
    assign mem_addr_c = ld_gnt_c ? bus.ld_addr : bus.f_addr;
    assign rdata_w    = bus.mem_rdata;

    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_we       = ld_gnt_c && bus.ld_we;
    assign bus.mem_wdata    = bus.ld_wdata;

    assign bus.f_gnt        = f_gnt_c;
    assign bus.ld_gnt       = ld_gnt_c;
    assign bus.f_rvalid     = f_rvalid_reg;
    assign bus.ld_rvalid    = ld_rvalid_reg;
    assign bus.f_rdata      = rdata_w;
    assign bus.ld_rdata     = rdata_w;
    assign bus.lock_active  = lock_active_reg;
    assign bus.lock_timeout = lock_timeout_reg;

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port, synchronous-read 256x32 instruction memory between two requesters: the core fetch stage (F) and a program loader/debug port (L, read or write). It arbitrates one access per cycle, muxes address and write data onto the memory port, and steers the 1-cycle-latency read data back to the winner with a valid strobe. A loader lock gives L exclusive access for program-load bursts; a watchdog bounds how long the lock can starve fetch.

Parameters:
ADDR_W, 8, word-address width (memory depth 2^ADDR_W)
DATA_W, 32, instruction word width
LOCK_MAX, 1024, maximum consecutive cycles ld_lock is honoured before timeout (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request
f_addr  in  ADDR_W  fetch word address
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  f_rdata valid (one cycle after f_gnt)
f_rdata  out  DATA_W  fetch read data
ld_req  in  1  loader request
ld_we  in  1  loader write (1) / read (0)
ld_addr  in  ADDR_W  loader word address
ld_wdata  in  DATA_W  loader write data
ld_lock  in  1  loader requests exclusive ownership (level)
ld_gnt  out  1  loader request accepted this cycle (combinational)
ld_rvalid  out  1  ld_rdata valid (loader reads only, one cycle after ld_gnt)
ld_rdata  out  DATA_W  loader read data
lock_active  out  1  lock currently honoured (registered)
lock_timeout  out  1  sticky: lock exceeded LOCK_MAX
mem_addr  out  ADDR_W  to memory address
mem_we  out  1  to memory write enable
mem_wdata  out  DATA_W  to memory write data
mem_rdata  in  DATA_W  from memory, registered read (valid cycle after address)

Behaviour:
- Reset (async, rst_n=0): f_rvalid=0, ld_rvalid=0, lock_active=0, lock_timeout=0, lock counter=0, rr_last=L, state=RUN; f_gnt, ld_gnt, mem_we forced 0 while rst_n=0. Responses pending at reset are dropped (no rvalid after release).
- Handshake: transfer occurs when req && gnt in the same cycle. At most one of f_gnt/ld_gnt high per cycle. Requester holds req/addr/data until granted; arbiter never grants without req.
- Memory mux: mem_addr = granted requester's address (f_addr when no grant); mem_we = ld_gnt && ld_we; mem_wdata = ld_wdata.
- Response: registered owner tag. Cycle after f_gnt: f_rvalid=1. Cycle after ld_gnt with ld_we=0: ld_rvalid=1. Loader writes produce no rvalid. f_rdata = ld_rdata = mem_rdata (qualified by rvalid). Back-to-back grants give back-to-back rvalids; full throughput, one access per cycle.
- States: RUN, LOCK, TIMEOUT.
  RUN: both requesting -> winner is requester not equal rr_last; single requester always wins. rr_last updates to winner on every grant. ld_lock=1 -> LOCK next cycle (in the transition cycle, normal arbitration still applies).
  LOCK: lock_active=1; f_gnt=0; ld_req granted every cycle. Counter increments each LOCK cycle. ld_lock=0 -> RUN, counter cleared. Counter reaches LOCK_MAX with ld_lock still 1 -> TIMEOUT, lock_timeout set.
  TIMEOUT: lock_active=0; round-robin as RUN (lock ignored). ld_lock=0 -> RUN; lock_timeout stays 1 until reset.
- Simultaneous: write and fetch of same address in one cycle impossible (one access/cycle); a fetch granted the cycle after a loader write to the same address returns the new data.
- Address width fixed ADDR_W; no wrap logic (memory indexes modulo depth).

Test Plan:
- Fetch only: f_req=1, f_addr=0x00..0x03 consecutive -> f_gnt=1 each cycle, f_rvalid=1 one cycle later with ROM[0..3], ld_rvalid=0.
- Contention: f_req=ld_req=1 (ld read) for 4 cycles after reset -> grants F,L,F,L; rvalids alternate accordingly with correct data.
- Load then fetch: ld write 0xDEADBEEF to addr 0x10, next cycle f_addr=0x10 -> f_rdata=0xDEADBEEF on f_rvalid; no ld_rvalid for write.
- Lock: ld_lock=1 with f_req held -> after transition cycle f_gnt=0, lock_active=1; release ld_lock -> RUN, F granted next contention.
- Timeout: LOCK_MAX=4, ld_lock held 10 cycles, f_req=1 -> lock_timeout=1 after 4 LOCK cycles, F grants resume alternating; flag stays 1 after ld_lock drops.
- Reset mid-op: assert rst_n=0 the cycle after f_gnt -> f_rvalid stays 0, all outputs at reset values; after release, F wins first contention.
